// File: rtl/ldpc_syndrome_gen.sv
// Streaming GF(2) syndrome generator for H = [I | P_A + P_B].
// Accumulates one codeword word per cycle and holds the result until consumed.
module ldpc_syndrome_gen #(
    parameter int M       = 256,
    parameter int W       = 32,
    parameter int SHIFT_A = 3,
    parameter int SHIFT_B = 77
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [W-1:0] cw_data,
    input  logic         cw_valid,
    output logic         cw_ready,
    output logic [M-1:0] syndrome,
    output logic         syn_valid,
    input  logic         syn_ready,
    output logic         syn_zero
);

    localparam int NW = 2 * M / W;
    localparam int MW = M / W;
    localparam int KW = $clog2(NW);

    typedef enum logic {ACC, HOLD} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [KW-1:0] k;
    logic [M-1:0]  acc;
    logic [M-1:0]  acc_nxt;
    logic [M-1:0]  placed;
    logic [M-1:0]  rot_a;
    logic [M-1:0]  rot_b;
    logic [M-1:0]  toggle;
    logic          upper;
    logic          accept;
    logic          last;
    logic          clear;

    assign accept = cw_valid && cw_ready;
    assign last   = (k == KW'(NW - 1));
    assign upper  = (k >= KW'(MW));
    assign clear  = flush || (state == HOLD && syn_ready);

    // Word lands at offset (k mod M/W)*W; upper half is then rotated by both circulants.
    always_comb begin
        placed = '0;
        for (int q = 0; q < MW; q++) begin
            if (k == KW'(q) || k == KW'(q + MW)) begin
                placed[q*W +: W] = cw_data;
            end
        end
        rot_a = '0;
        rot_b = '0;
        for (int j = 0; j < M; j++) begin
            rot_a[j] = placed[(j + SHIFT_A) % M];
            rot_b[j] = placed[(j + SHIFT_B) % M];
        end
        toggle  = upper ? (rot_a ^ rot_b) : placed;
        acc_nxt = acc ^ toggle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ACC;
        end else begin
            unique case (state)
                ACC:  if (accept && last) state_nxt = HOLD;
                HOLD: if (syn_ready) state_nxt = ACC;
                default: state_nxt = ACC;
            endcase
        end
    end

    always_comb begin
        cw_ready  = (state == ACC) && !flush;
        syn_valid = (state == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            k        <= '0;
            syn_zero <= 1'b0;
        end else if (clear) begin
            acc      <= '0;
            k        <= '0;
            syn_zero <= 1'b0;
        end else if (accept) begin
            acc <= acc_nxt;
            k   <= last ? '0 : k + KW'(1);
            if (last) begin
                syn_zero <= (acc_nxt == '0);
            end
        end
    end

    assign syndrome = acc;

endmodule

// File: tb/tb_ldpc_syndrome_gen.sv
// Directed bench for ldpc_syndrome_gen at default parameters.
// Expected syndromes are hand-derived from H = [I | P_3 + P_77].
module tb_ldpc_syndrome_gen;

    localparam int M  = 256;
    localparam int W  = 32;
    localparam int NW = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic [W-1:0] cw_data = '0;
    logic         cw_valid = 1'b0;
    logic         cw_ready;
    logic [M-1:0] syndrome;
    logic         syn_valid;
    logic         syn_ready = 1'b1;
    logic         syn_zero;

    int vectors = 0;
    int errors  = 0;

    logic [W-1:0] fr [NW];
    logic [M-1:0] exp_syn;
    logic [M-1:0] snap;

    ldpc_syndrome_gen dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .cw_data(cw_data),
        .cw_valid(cw_valid),
        .cw_ready(cw_ready),
        .syndrome(syndrome),
        .syn_valid(syn_valid),
        .syn_ready(syn_ready),
        .syn_zero(syn_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_frame();
        for (int i = 0; i < NW; i++) fr[i] = '0;
    endtask

    task automatic push(input logic [W-1:0] d);
        cw_valid = 1'b1;
        cw_data  = d;
        tick();
        cw_valid = 1'b0;
        cw_data  = '0;
    endtask

    // Sends words 0..14 of fr; the caller pushes word 15 and checks.
    task automatic send_head(input bit gaps);
        for (int i = 0; i < NW - 1; i++) begin
            push(fr[i]);
            if (gaps && (i % 3 == 1)) tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (cw_ready !== 1'b1 || syn_valid !== 1'b0 || syn_zero !== 1'b0
            || syndrome !== '0) begin
            errors++;
            $display("FAIL reset_in: rdy=%b val=%b zero=%b syn=%h", cw_ready,
                     syn_valid, syn_zero, syndrome);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (cw_ready !== 1'b1 || syn_valid !== 1'b0 || syndrome !== '0) begin
            errors++;
            $display("FAIL reset_out: rdy=%b val=%b syn=%h", cw_ready,
                     syn_valid, syndrome);
        end
    endtask

    task automatic test_zero_frame();
        clear_frame();
        send_head(1'b0);
        vectors++;
        if (syn_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_early: syn_valid=%b want 0", syn_valid);
        end
        push(fr[NW-1]);
        vectors++;
        if (syn_valid !== 1'b1 || syndrome !== '0 || syn_zero !== 1'b1) begin
            errors++;
            $display("FAIL zero_frame: val=%b zero=%b syn=%h want 1 1 0",
                     syn_valid, syn_zero, syndrome);
        end
        tick();
        vectors++;
        if (syn_valid !== 1'b0 || cw_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_one_cycle: val=%b rdy=%b want 0 1",
                     syn_valid, cw_ready);
        end
    endtask

    task automatic test_identity_bit();
        clear_frame();
        fr[0] = 32'h0000_0020;
        send_head(1'b0);
        push(fr[NW-1]);
        exp_syn = '0;
        exp_syn[5] = 1'b1;
        vectors++;
        if (syn_valid !== 1'b1 || syndrome !== exp_syn || syn_zero !== 1'b0) begin
            errors++;
            $display("FAIL ident_bit5: val=%b zero=%b syn=%h want %h",
                     syn_valid, syn_zero, syndrome, exp_syn);
        end
        tick();
    endtask

    task automatic test_wrap();
        clear_frame();
        fr[8] = 32'h0000_0001;
        send_head(1'b0);
        push(fr[NW-1]);
        exp_syn = '0;
        exp_syn[253] = 1'b1;
        exp_syn[179] = 1'b1;
        vectors++;
        if (syn_valid !== 1'b1 || syndrome !== exp_syn || syn_zero !== 1'b0) begin
            errors++;
            $display("FAIL wrap_c256: syn=%h want %h", syndrome, exp_syn);
        end
        tick();
    endtask

    task automatic test_cancel_stall();
        clear_frame();
        fr[0] = 32'h0000_0001;
        fr[8] = 32'h0000_0008;
        send_head(1'b1);
        vectors++;
        if (syn_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_early: syn_valid=%b want 0", syn_valid);
        end
        push(fr[NW-1]);
        exp_syn = '0;
        exp_syn[182] = 1'b1;
        vectors++;
        if (syn_valid !== 1'b1 || syndrome !== exp_syn) begin
            errors++;
            $display("FAIL cancel_c0_c259: val=%b syn=%h want %h", syn_valid,
                     syndrome, exp_syn);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int bad;
        clear_frame();
        fr[0] = 32'h0000_0020;
        syn_ready = 1'b0;
        send_head(1'b0);
        push(fr[NW-1]);
        snap = syndrome;
        exp_syn = '0;
        exp_syn[5] = 1'b1;
        vectors++;
        if (syn_valid !== 1'b1 || snap !== exp_syn) begin
            errors++;
            $display("FAIL bp_result: val=%b syn=%h want %h", syn_valid, snap,
                     exp_syn);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            cw_valid = 1'b1;
            cw_data  = 32'hDEAD_BEEF ^ i;
            #1;
            if (cw_ready !== 1'b0) bad++;
            tick();
            if (syn_valid !== 1'b1 || syndrome !== snap || syn_zero !== 1'b0) bad++;
        end
        cw_valid = 1'b0;
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d bad cycles, want 0", bad);
        end
        syn_ready = 1'b1;
        tick();
        vectors++;
        if (syn_valid !== 1'b0 || syndrome !== '0) begin
            errors++;
            $display("FAIL bp_release: val=%b syn=%h want 0 0", syn_valid,
                     syndrome);
        end
        clear_frame();
        fr[8] = 32'h0000_0001;
        send_head(1'b0);
        push(fr[NW-1]);
        exp_syn = '0;
        exp_syn[253] = 1'b1;
        exp_syn[179] = 1'b1;
        vectors++;
        if (syn_valid !== 1'b1 || syndrome !== exp_syn) begin
            errors++;
            $display("FAIL bp_next_frame: syn=%h want %h", syndrome, exp_syn);
        end
        tick();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 7; i++) push(32'hFFFF_FFFF);
        flush    = 1'b1;
        cw_valid = 1'b1;
        cw_data  = 32'hFFFF_FFFF;
        #1;
        vectors++;
        if (cw_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: cw_ready=%b want 0", cw_ready);
        end
        tick();
        flush    = 1'b0;
        cw_valid = 1'b0;
        vectors++;
        if (syndrome !== '0 || syn_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: syn=%h val=%b want 0 0", syndrome,
                     syn_valid);
        end
        clear_frame();
        send_head(1'b0);
        vectors++;
        if (syn_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_count: syn_valid=%b want 0", syn_valid);
        end
        push(fr[NW-1]);
        vectors++;
        if (syn_valid !== 1'b1 || syn_zero !== 1'b1 || syndrome !== '0) begin
            errors++;
            $display("FAIL flush_frame: val=%b zero=%b syn=%h want 1 1 0",
                     syn_valid, syn_zero, syndrome);
        end
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) push(32'hFFFF_FFFF);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (syndrome !== '0 || syn_valid !== 1'b0 || syn_zero !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: syn=%h val=%b zero=%b want 0", syndrome,
                     syn_valid, syn_zero);
        end
        tick();
        rst = 1'b0;
        tick();
        clear_frame();
        send_head(1'b0);
        vectors++;
        if (syn_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_count: syn_valid=%b want 0", syn_valid);
        end
        push(fr[NW-1]);
        vectors++;
        if (syn_valid !== 1'b1 || syn_zero !== 1'b1 || syndrome !== '0) begin
            errors++;
            $display("FAIL rst_frame: val=%b zero=%b syn=%h want 1 1 0",
                     syn_valid, syn_zero, syndrome);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_identity_bit();
        test_wrap();
        test_cancel_stall();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
